// File: rtl/i2c_slave.sv
// I2C target at address ADDR bridging bus transfers onto a byte-wide register bus.
// Optional: define I2C_SLAVE_FILTER_EN for a FILTER_LEN-sample glitch filter on scl/sda.
module i2c_slave #(
    parameter logic [6:0] ADDR       = 7'h42,
    parameter int         FILTER_LEN = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl,
    inout  tri         sda,
    input  logic [7:0] rd_data,
    output logic [7:0] reg_addr,
    output logic [7:0] wr_data,
    output logic       wr_en,
    output logic       rd_en,
    output logic       busy
);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_IGNORE
    } state_t;

    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("FILTER_LEN must be at least 1");
    end

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_f, sda_f, scl_p_q, sda_p_q;
    logic       scl_rise, scl_fall, start_ev, stop_ev;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] reg_addr_q, reg_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic       oe_q, oe_d, busy_q, busy_d, rw_q, rw_d;
    logic       rd_cap_q;

    // Two-flop synchronizer; idle bus level is high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl};
            sda_sync_q <= {sda_sync_q[0], sda};
        end
    end

`ifdef I2C_SLAVE_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);
    logic [CW-1:0] scl_cnt_q, sda_cnt_q;
    logic          scl_flt_q, sda_flt_q;

    // Accept a new level only after FILTER_LEN consecutive equal samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_cnt_q <= '0;
            sda_cnt_q <= '0;
            scl_flt_q <= 1'b1;
            sda_flt_q <= 1'b1;
        end else begin
            if (scl_sync_q[1] == scl_flt_q) begin
                scl_cnt_q <= '0;
            end else if (scl_cnt_q == CW'(FILTER_LEN - 1)) begin
                scl_cnt_q <= '0;
                scl_flt_q <= scl_sync_q[1];
            end else begin
                scl_cnt_q <= scl_cnt_q + CW'(1);
            end
            if (sda_sync_q[1] == sda_flt_q) begin
                sda_cnt_q <= '0;
            end else if (sda_cnt_q == CW'(FILTER_LEN - 1)) begin
                sda_cnt_q <= '0;
                sda_flt_q <= sda_sync_q[1];
            end else begin
                sda_cnt_q <= sda_cnt_q + CW'(1);
            end
        end
    end

    assign scl_f = scl_flt_q;
    assign sda_f = sda_flt_q;
`else
    assign scl_f = scl_sync_q[1];
    assign sda_f = sda_sync_q[1];
`endif

    // Previous levels for edge and bus-condition detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_p_q <= 1'b1;
            sda_p_q <= 1'b1;
        end else begin
            scl_p_q <= scl_f;
            sda_p_q <= sda_f;
        end
    end

    assign scl_rise = scl_f & ~scl_p_q;
    assign scl_fall = ~scl_f & scl_p_q;
    assign start_ev = scl_f & scl_p_q & sda_p_q & ~sda_f;
    assign stop_ev  = scl_f & scl_p_q & ~sda_p_q & sda_f;

    // Protocol FSM: next state, shifter, pointer and strobes
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        reg_addr_d = reg_addr_q;
        wr_data_d  = wr_data_q;
        wr_en_d    = 1'b0;
        rd_en_d    = 1'b0;
        oe_d       = oe_q;
        busy_d     = busy_q;
        rw_d       = rw_q;

        if (rd_cap_q) begin
            shift_d = rd_data;
            if (state_q == S_RDATA) oe_d = ~rd_data[7];
        end
        if (wr_en_q) reg_addr_d = reg_addr_q + 8'd1;

        case (state_q)
            S_IDLE, S_IGNORE: ;
            S_ADDR: begin
                if (scl_rise && cnt_q < 4'd8) begin
                    shift_d = {shift_q[6:0], sda_f};
                    cnt_d   = cnt_q + 4'd1;
                end else if (scl_fall && cnt_q == 4'd8) begin
                    if (shift_q[7:1] == ADDR) begin
                        oe_d    = 1'b1;
                        busy_d  = 1'b1;
                        rw_d    = shift_q[0];
                        rd_en_d = shift_q[0];
                        state_d = S_ADDR_ACK;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = S_IGNORE;
                    end
                end
            end
            S_ADDR_ACK: begin
                if (scl_fall) begin
                    cnt_d   = 4'd0;
                    oe_d    = rw_q ? ~shift_q[7] : 1'b0;
                    state_d = rw_q ? S_RDATA : S_PTR;
                end
            end
            S_PTR, S_WDATA: begin
                if (scl_rise && cnt_q < 4'd8) begin
                    shift_d = {shift_q[6:0], sda_f};
                    cnt_d   = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        if (state_q == S_PTR) begin
                            reg_addr_d = {shift_q[6:0], sda_f};
                        end else begin
                            wr_data_d = {shift_q[6:0], sda_f};
                            wr_en_d   = 1'b1;
                        end
                    end
                end else if (scl_fall && cnt_q == 4'd8) begin
                    oe_d    = 1'b1;
                    state_d = (state_q == S_PTR) ? S_PTR_ACK : S_WDATA_ACK;
                end
            end
            S_PTR_ACK, S_WDATA_ACK: begin
                if (scl_fall) begin
                    oe_d    = 1'b0;
                    cnt_d   = 4'd0;
                    state_d = S_WDATA;
                end
            end
            S_RDATA: begin
                if (scl_fall) begin
                    if (cnt_q == 4'd7) begin
                        oe_d    = 1'b0;
                        state_d = S_RDATA_ACK;
                    end else begin
                        shift_d = {shift_q[6:0], 1'b0};
                        oe_d    = ~shift_q[6];
                        cnt_d   = cnt_q + 4'd1;
                    end
                end
            end
            S_RDATA_ACK: begin
                if (scl_rise) begin
                    reg_addr_d = reg_addr_q + 8'd1;
                    cnt_d      = 4'd8;
                    if (sda_f) state_d = S_IGNORE;
                end else if (scl_fall && cnt_q == 4'd8) begin
                    rd_en_d = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_RDATA;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start_ev) begin
            state_d = S_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            wr_en_d = 1'b0;
            rd_en_d = 1'b0;
        end else if (stop_ev) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            wr_en_d = 1'b0;
            rd_en_d = 1'b0;
        end
    end

    // FSM and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            shift_q    <= 8'd0;
            reg_addr_q <= 8'd0;
            wr_data_q  <= 8'd0;
            wr_en_q    <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_cap_q   <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
            rw_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            reg_addr_q <= reg_addr_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
            rd_en_q    <= rd_en_d;
            rd_cap_q   <= rd_en_q;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            rw_q       <= rw_d;
        end
    end

    assign sda      = oe_q ? 1'b0 : 1'bz;
    assign reg_addr = reg_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_en    = wr_en_q;
    assign rd_en    = rd_en_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bit-banged I2C master plus register-bank model around i2c_slave.
// Strobes are checked by a scoreboard monitor; bus replies by the master tasks.
`timescale 1ns/1ps
module tb_i2c_slave;

    localparam logic [6:0] DEV = 7'h42;
    localparam int Q = 8;

    typedef struct {
        bit         is_wr;
        logic [7:0] a;
        logic [7:0] d;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda_low = 1'b0;
    logic [7:0] rd_data = 8'h00;
    logic [7:0] reg_addr, wr_data;
    logic       wr_en, rd_en, busy;
    wire        sda;

    pullup (sda);
    assign sda = m_sda_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_slave dut (
        .clk(clk), .reset(reset), .scl(m_scl), .sda(sda),
        .rd_data(rd_data), .reg_addr(reg_addr), .wr_data(wr_data),
        .wr_en(wr_en), .rd_en(rd_en), .busy(busy)
    );

    int         total = 0;
    int         bad = 0;
    int         dut_low = 0;
    ev_t        sb[$];
    logic [7:0] ref_mem [256];
    logic [7:0] ptr_m;
    logic [7:0] bank [256];
    logic       pl_en = 1'b0;
    logic [7:0] pl_a = 8'h00, pl_d = 8'h00;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Register bank: registered read, one cycle after rd_en
    always @(posedge clk) begin
        if (pl_en) bank[pl_a] <= pl_d;
        else if (wr_en) bank[reg_addr] <= wr_data;
        if (rd_en) rd_data <= bank[reg_addr];
    end

    // Scoreboard monitor
    always @(negedge clk) begin
        ev_t e;
        if (wr_en && rd_en) chk("strobe_overlap", int'({wr_en, rd_en}), 2);
        if (wr_en) begin
            chk("wr_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("wr_kind", int'(e.is_wr), 1);
                chk("wr_addr", int'(reg_addr), int'(e.a));
                chk("wr_data", int'(wr_data), int'(e.d));
            end
        end
        if (rd_en) begin
            chk("rd_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rd_kind", int'(e.is_wr), 0);
                chk("rd_addr", int'(reg_addr), int'(e.a));
            end
        end
        if (!m_sda_low && sda === 1'b0) dut_low++;
    end

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        pl_a = a; pl_d = d; pl_en = 1'b1;
        wq(1);
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic m_start();
        if (!m_scl) begin
            m_sda_low = 1'b0; wq(Q);
            m_scl = 1'b1; wq(Q);
        end else begin
            wq(Q);
        end
        m_sda_low = 1'b1; wq(2 * Q);
        m_scl = 1'b0; wq(Q);
    endtask

    task automatic m_stop();
        m_sda_low = 1'b1; wq(Q);
        m_scl = 1'b1; wq(2 * Q);
        m_sda_low = 1'b0; wq(2 * Q);
    endtask

    task automatic wbit(input bit b);
        m_sda_low = ~b; wq(Q);
        m_scl = 1'b1; wq(2 * Q);
        m_scl = 1'b0; wq(Q);
    endtask

    task automatic rbit(output bit b);
        m_sda_low = 1'b0; wq(Q);
        m_scl = 1'b1; wq(Q);
        b = (sda !== 1'b0);
        wq(Q);
        m_scl = 1'b0; wq(Q);
    endtask

    task automatic wr_byte(input logic [7:0] b, output bit ack);
        bit r;
        for (int i = 7; i >= 0; i--) wbit(b[i]);
        rbit(r);
        ack = ~r;
    endtask

    task automatic rd_byte(output logic [7:0] b, input bit nack);
        bit r;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            rbit(r);
            b = {b[6:0], r};
        end
        wbit(nack);
    endtask

    // Address + pointer + n data bytes, then STOP
    task automatic xfer_write(input logic [6:0] a7, input logic [7:0] ptr,
                              input int n, input logic [7:0] dat [4]);
        bit ack;
        bit match = (a7 == DEV);
        m_start();
        wr_byte({a7, 1'b0}, ack);
        chk("w_addr_ack", int'(ack), int'(match));
        if (match) begin
            chk("w_busy", int'(busy), 1);
            wr_byte(ptr, ack);
            chk("w_ptr_ack", int'(ack), 1);
            ptr_m = ptr;
            for (int i = 0; i < n; i++) begin
                sb.push_back('{1'b1, ptr_m, dat[i]});
                ref_mem[ptr_m] = dat[i];
                wr_byte(dat[i], ack);
                chk("w_data_ack", int'(ack), 1);
                ptr_m = ptr_m + 8'd1;
            end
        end
        m_stop();
        chk("w_busy_off", int'(busy), 0);
        chk("w_reg_addr", int'(reg_addr), int'(ptr_m));
    endtask

    // Pointer write, repeated START, n read bytes (last NACKed), STOP
    task automatic xfer_read(input logic [7:0] ptr, input int n);
        bit ack;
        logic [7:0] b;
        m_start();
        wr_byte({DEV, 1'b0}, ack);
        chk("r_addr_ack", int'(ack), 1);
        wr_byte(ptr, ack);
        chk("r_ptr_ack", int'(ack), 1);
        ptr_m = ptr;
        m_start();
        sb.push_back('{1'b0, ptr_m, 8'h00});
        wr_byte({DEV, 1'b1}, ack);
        chk("r_addr2_ack", int'(ack), 1);
        for (int i = 0; i < n; i++) begin
            if (i < n - 1) sb.push_back('{1'b0, ptr_m + 8'd1, 8'h00});
            rd_byte(b, i == n - 1);
            chk("r_data", int'(b), int'(ref_mem[ptr_m]));
            ptr_m = ptr_m + 8'd1;
        end
        chk("r_sda_released", int'(sda === 1'b1), 1);
        m_stop();
        chk("r_busy_off", int'(busy), 0);
        chk("r_reg_addr", int'(reg_addr), int'(ptr_m));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        bit         ack;
        int         base;
        logic [7:0] d [4];
        logic [6:0] a7;

        ptr_m = 8'h00;
        wq(3);
        chk("rst_reg_addr", int'(reg_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_strobes", int'({wr_en, rd_en}), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_sda", int'(sda === 1'b1), 1);
        reset = 1'b1;
        wq(2);
        for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));

        d = '{8'hA5, 8'h5A, 8'h00, 8'h00};
        xfer_write(DEV, 8'h10, 2, d);

        preload(8'h20, 8'hC3);
        preload(8'h21, 8'h3C);
        xfer_read(8'h20, 2);

        base = dut_low;
        m_start();
        wr_byte(8'h86, ack);
        chk("mm_addr_nack", int'(ack), 0);
        wr_byte(8'h11, ack);
        chk("mm_data_nack", int'(ack), 0);
        m_stop();
        chk("mm_no_drive", dut_low - base, 0);
        chk("mm_busy", int'(busy), 0);

        m_start();
        wr_byte({DEV, 1'b0}, ack);
        chk("wrap_addr_ack", int'(ack), 1);
        wr_byte(8'hFF, ack);
        ptr_m = 8'hFF;
        for (int i = 1; i <= 2; i++) begin
            sb.push_back('{1'b1, ptr_m, 8'(i)});
            ref_mem[ptr_m] = 8'(i);
            wr_byte(8'(i), ack);
            chk("wrap_data_ack", int'(ack), 1);
            ptr_m = ptr_m + 8'd1;
        end
        wbit(1'b0); wbit(1'b0); wbit(1'b1); wbit(1'b1);
        m_start();
        wr_byte({DEV, 1'b0}, ack);
        chk("abort_readdr_ack", int'(ack), 1);
        m_stop();
        chk("wrap_reg_addr", int'(reg_addr), 8'h01);

        preload(8'h30, 8'h15);
        m_start();
        wr_byte({DEV, 1'b0}, ack);
        wr_byte(8'h30, ack);
        m_start();
        sb.push_back('{1'b0, 8'h30, 8'h00});
        wr_byte({DEV, 1'b1}, ack);
        chk("mr_addr_ack", int'(ack), 1);
        m_sda_low = 1'b0; wq(Q);
        m_scl = 1'b1; wq(Q);
        chk("mr_bit_driven", int'(sda === 1'b0), 1);
        #2 reset = 1'b0;
        #1 chk("mr_sda_async", int'(sda === 1'b1), 1);
        wq(1);
        chk("mr_reg_addr", int'(reg_addr), 0);
        chk("mr_wr_data", int'(wr_data), 0);
        chk("mr_strobes", int'({wr_en, rd_en}), 0);
        chk("mr_busy", int'(busy), 0);
        wq(2);
        reset = 1'b1;
        ptr_m = 8'h00;
        wq(4 * Q);
        d = '{8'h77, 8'h00, 8'h00, 8'h00};
        xfer_write(DEV, 8'h05, 1, d);

`ifdef I2C_SLAVE_FILTER_EN
        m_sda_low = 1'b1; wq(2);
        m_sda_low = 1'b0; wq(Q);
        m_scl = 1'b0; wq(Q);
        wr_byte({DEV, 1'b0}, ack);
        chk("flt_no_start", int'(ack), 0);
        m_stop();
`endif

        for (int k = 0; k < 10; k++) begin
            int n = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) d[i] = 8'($urandom);
            if ($urandom_range(0, 2) == 2) begin
                xfer_read(8'($urandom), n);
            end else begin
                a7 = DEV;
                if ($urandom_range(0, 3) == 0) begin
                    a7 = 7'($urandom_range(0, 127));
                    if (a7 == DEV) a7 = 7'h43;
                end
                xfer_write(a7, 8'($urandom), n, d);
            end
        end

        wq(10);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
